// File: rtl/oled_spi_rx.sv
// Receive-side deserialiser and SSD1306 command decoder for the PmodOLED link.
// Turns the controller's pin traffic into bytes and addressed frame-buffer writes.
module oled_spi_rx #(
    parameter int NUM_COLS  = 128,
    parameter int NUM_PAGES = 4,
    parameter int ADDR_W    = 9
) (
    input  logic              CLK100MHZ,
    input  logic              RST,
    input  logic              CS,
    input  logic              SCLK,
    input  logic              SDIN,
    input  logic              DC,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic              byte_dc,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              disp_on,
    output logic              cmd_err
);

    localparam int COL_W  = $clog2(NUM_COLS);
    localparam int PAGE_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int PIN_CS   = 3;
    localparam int PIN_SCLK = 2;
    localparam int PIN_SDIN = 1;
    localparam int PIN_DC   = 0;
    localparam logic [3:0] PIN_IDLE = 4'b1100;
    localparam logic [7:0] COL_MAX8  = 8'(NUM_COLS - 1);
    localparam logic [2:0] PAGE_MAX3 = 3'(NUM_PAGES - 1);

    typedef enum logic [2:0] {
        ST_CMD, ST_COL_S, ST_COL_E, ST_PG_S, ST_PG_E, ST_SKIP1, ST_SKIP2
    } state_t;

    logic [3:0] pins_in;
    logic [3:0] pins_sync;
    logic [3:0] pins_hist;

    assign pins_in = {CS, SCLK, SDIN, DC};

    // Sync chains reset to the bus idle levels so a reset with CS low cannot fake an SCLK edge.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            logic hist_reg;
            always_ff @(posedge CLK100MHZ) begin
                if (RST) begin
                    meta_reg <= PIN_IDLE[gi];
                    sync_reg <= PIN_IDLE[gi];
                    hist_reg <= PIN_IDLE[gi];
                end else begin
                    meta_reg <= pins_in[gi];
                    sync_reg <= meta_reg;
                    hist_reg <= sync_reg;
                end
            end
            assign pins_sync[gi] = sync_reg;
            assign pins_hist[gi] = hist_reg;
        end
    endgenerate

    logic sclk_rise;
    logic cs_rise;
    logic sdin_bit;
    logic dc_bit;

    assign sclk_rise = pins_sync[PIN_SCLK] & ~pins_hist[PIN_SCLK] & ~pins_sync[PIN_CS];
    assign cs_rise   = pins_sync[PIN_CS] & ~pins_hist[PIN_CS];
    // SDIN/DC taken from the history stage: the level held just before the SCLK rise.
    assign sdin_bit  = pins_hist[PIN_SDIN];
    assign dc_bit    = pins_hist[PIN_DC];

    logic [2:0] bit_cnt_reg;
    logic [6:0] shreg_reg;

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
            byte_valid  <= 1'b0;
            byte_data   <= '0;
            byte_dc     <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (cs_rise) begin
                bit_cnt_reg <= '0;
                if (bit_cnt_reg != 3'd0) begin
                    cmd_err <= 1'b1;
                end
            end else if (sclk_rise) begin
                shreg_reg <= {shreg_reg[5:0], sdin_bit};
                if (bit_cnt_reg == 3'd7) begin
                    byte_data   <= {shreg_reg, sdin_bit};
                    byte_dc     <= dc_bit;
                    byte_valid  <= 1'b1;
                    bit_cnt_reg <= '0;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end
            end
        end
    end

    state_t              state_reg, state_next;
    logic [COL_W-1:0]    col_reg, col_next;
    logic [COL_W-1:0]    col_start_reg, col_start_next;
    logic [COL_W-1:0]    col_end_reg, col_end_next;
    logic [PAGE_W-1:0]   page_reg, page_next;
    logic [PAGE_W-1:0]   page_start_reg, page_start_next;
    logic [PAGE_W-1:0]   page_end_reg, page_end_next;
    logic                wr_en_next;
    logic [ADDR_W-1:0]   wr_addr_next;
    logic [7:0]          wr_data_next;
    logic                disp_next;
    logic [7:0]          col_arg;
    logic [2:0]          pg_arg;

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state_reg <= ST_CMD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (byte_valid && !byte_dc) begin
            case (state_reg)
                ST_CMD: begin
                    case (byte_data)
                        8'h21: state_next = ST_COL_S;
                        8'h22: state_next = ST_PG_S;
                        8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
                        8'hD5, 8'hD9, 8'hDA, 8'hDB: state_next = ST_SKIP1;
                        8'h26, 8'h27, 8'h29, 8'h2A, 8'hA3: state_next = ST_SKIP2;
                        default: state_next = ST_CMD;
                    endcase
                end
                ST_COL_S: state_next = ST_COL_E;
                ST_COL_E: state_next = ST_CMD;
                ST_PG_S:  state_next = ST_PG_E;
                ST_PG_E:  state_next = ST_CMD;
                ST_SKIP1: state_next = ST_CMD;
                ST_SKIP2: state_next = ST_SKIP1;
                default:  state_next = ST_CMD;
            endcase
        end
    end

    always_comb begin
        col_next        = col_reg;
        col_start_next  = col_start_reg;
        col_end_next    = col_end_reg;
        page_next       = page_reg;
        page_start_next = page_start_reg;
        page_end_next   = page_end_reg;
        wr_en_next      = 1'b0;
        wr_addr_next    = wr_addr;
        wr_data_next    = wr_data;
        disp_next       = disp_on;
        col_arg = (byte_data > COL_MAX8) ? COL_MAX8 : byte_data;
        pg_arg  = (byte_data[2:0] > PAGE_MAX3) ? PAGE_MAX3 : byte_data[2:0];
        if (byte_valid) begin
            if (byte_dc) begin
                wr_en_next   = 1'b1;
                wr_addr_next = ADDR_W'(page_reg) * ADDR_W'(NUM_COLS) + ADDR_W'(col_reg);
                wr_data_next = byte_data;
                // Horizontal addressing: column wraps to window start and steps the page.
                if (col_reg == col_end_reg) begin
                    col_next  = col_start_reg;
                    page_next = (page_reg == page_end_reg) ? page_start_reg
                                                           : page_reg + PAGE_W'(1);
                end else begin
                    col_next = col_reg + COL_W'(1);
                end
            end else begin
                case (state_reg)
                    ST_CMD: begin
                        if (byte_data[7:4] == 4'h0) begin
                            col_next = COL_W'({col_reg[COL_W-1:4], byte_data[3:0]});
                        end else if (byte_data[7:3] == 5'b00010) begin
                            col_next = COL_W'({byte_data[2:0], col_reg[3:0]});
                        end else if (byte_data[7:3] == 5'b10110) begin
                            if (byte_data[2:0] <= PAGE_MAX3) begin
                                page_next = PAGE_W'(byte_data[2:0]);
                            end
                        end else if (byte_data == 8'hAE) begin
                            disp_next = 1'b0;
                        end else if (byte_data == 8'hAF) begin
                            disp_next = 1'b1;
                        end
                    end
                    ST_COL_S: begin
                        col_start_next = COL_W'(col_arg);
                        col_next       = COL_W'(col_arg);
                    end
                    ST_COL_E: col_end_next = COL_W'(col_arg);
                    ST_PG_S: begin
                        page_start_next = PAGE_W'(pg_arg);
                        page_next       = PAGE_W'(pg_arg);
                    end
                    ST_PG_E: page_end_next = PAGE_W'(pg_arg);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            col_reg        <= '0;
            col_start_reg  <= '0;
            col_end_reg    <= COL_W'(NUM_COLS - 1);
            page_reg       <= '0;
            page_start_reg <= '0;
            page_end_reg   <= PAGE_W'(NUM_PAGES - 1);
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            disp_on        <= 1'b0;
        end else begin
            col_reg        <= col_next;
            col_start_reg  <= col_start_next;
            col_end_reg    <= col_end_next;
            page_reg       <= page_next;
            page_start_reg <= page_start_next;
            page_end_reg   <= page_end_next;
            wr_en          <= wr_en_next;
            wr_addr        <= wr_addr_next;
            wr_data        <= wr_data_next;
            disp_on        <= disp_next;
        end
    end

endmodule

// File: tb/tb_oled_spi_rx.sv
// Self-checking bench for oled_spi_rx: drives the four OLED pins at SCLK = CLK/8
// and compares bytes and frame-buffer writes against a behavioural display model.
`timescale 1ns/1ps
module tb_oled_spi_rx;
    localparam int NUM_COLS  = 128;
    localparam int NUM_PAGES = 4;
    localparam int ADDR_W    = 9;

    logic CLK100MHZ = 1'b0;
    logic RST = 1'b1, CS = 1'b1, SCLK = 1'b1, SDIN = 1'b0, DC = 1'b0;
    logic byte_valid, byte_dc, wr_en, disp_on, cmd_err;
    logic [7:0] byte_data, wr_data;
    logic [ADDR_W-1:0] wr_addr;

    always #5 CLK100MHZ = ~CLK100MHZ;

    oled_spi_rx #(.NUM_COLS(NUM_COLS), .NUM_PAGES(NUM_PAGES), .ADDR_W(ADDR_W)) dut (
        .CLK100MHZ(CLK100MHZ), .RST(RST), .CS(CS), .SCLK(SCLK), .SDIN(SDIN), .DC(DC),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .disp_on(disp_on), .cmd_err(cmd_err)
    );

    int checks = 0;
    int fails  = 0;
    longint cyc = 0;

    typedef struct { logic [7:0] data; logic dc; longint t; } byte_ev_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] data; longint t; } wr_ev_t;
    byte_ev_t obs_bytes[$];
    wr_ev_t   obs_wrs[$];
    logic [7:0] exp_b_data[$];
    logic       exp_b_dc[$];
    int         exp_w_addr[$];
    logic [7:0] exp_w_data[$];

    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    always @(negedge CLK100MHZ) begin
        if (byte_valid === 1'b1) obs_bytes.push_back('{byte_data, byte_dc, cyc});
        if (wr_en === 1'b1) obs_wrs.push_back('{wr_addr, wr_data, cyc});
    end

    // Display model: cursor, window, display flag, and how many argument bytes are owed.
    int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_disp, m_mode, m_argi, m_skip;

    function automatic void model_reset();
        m_col = 0; m_page = 0; m_cs = 0; m_ce = NUM_COLS - 1;
        m_ps = 0; m_pe = NUM_PAGES - 1; m_disp = 0; m_mode = 0; m_argi = 0; m_skip = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input logic dc);
        int v, p;
        v = int'(b);
        exp_b_data.push_back(b);
        exp_b_dc.push_back(dc);
        if (dc) begin
            exp_w_addr.push_back(m_page * NUM_COLS + m_col);
            exp_w_data.push_back(b);
            if (m_col == m_ce) begin
                m_col = m_cs;
                m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % NUM_PAGES;
            end else begin
                m_col = (m_col + 1) % NUM_COLS;
            end
        end else if (m_mode == 1) begin
            if (m_argi == 0) begin
                m_cs = (v > NUM_COLS - 1) ? NUM_COLS - 1 : v; m_col = m_cs; m_argi = 1;
            end else begin
                m_ce = (v > NUM_COLS - 1) ? NUM_COLS - 1 : v; m_mode = 0;
            end
        end else if (m_mode == 2) begin
            p = v % 8;
            if (p > NUM_PAGES - 1) p = NUM_PAGES - 1;
            if (m_argi == 0) begin
                m_ps = p; m_page = p; m_argi = 1;
            end else begin
                m_pe = p; m_mode = 0;
            end
        end else if (m_skip > 0) begin
            m_skip = m_skip - 1;
        end else if (v == 'h21) begin
            m_mode = 1; m_argi = 0;
        end else if (v == 'h22) begin
            m_mode = 2; m_argi = 0;
        end else if (v < 'h10) begin
            m_col = (m_col / 16) * 16 + v;
        end else if (v <= 'h17) begin
            m_col = ((v % 8) * 16 + m_col % 16) % NUM_COLS;
        end else if (v >= 'hB0 && v <= 'hB7) begin
            if (v - 'hB0 < NUM_PAGES) m_page = v - 'hB0;
        end else if (v == 'hAE) begin
            m_disp = 0;
        end else if (v == 'hAF) begin
            m_disp = 1;
        end else if (v inside {'h20, 'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB}) begin
            m_skip = 1;
        end else if (v inside {'h26, 'h27, 'h29, 'h2A, 'hA3}) begin
            m_skip = 2;
        end
    endfunction

    task automatic spi_bit(input logic b);
        SCLK = 1'b0; SDIN = b;
        repeat (4) @(negedge CLK100MHZ);
        SCLK = 1'b1;
        repeat (4) @(negedge CLK100MHZ);
    endtask

    task automatic cs_assert();
        CS = 1'b0;
        repeat (4) @(negedge CLK100MHZ);
    endtask

    task automatic cs_release();
        repeat (4) @(negedge CLK100MHZ);
        CS = 1'b1;
        repeat (6) @(negedge CLK100MHZ);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        DC = dc;
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
        model_byte(b, dc);
        $display("[%0t] tx byte=%02h dc=%0d", $time, b, dc);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic dc);
        cs_assert();
        send_byte(b, dc);
        cs_release();
    endtask

    task automatic flush();
        repeat (12) @(negedge CLK100MHZ);
    endtask

    task automatic do_reset();
        @(negedge CLK100MHZ);
        RST = 1'b1; CS = 1'b1; SCLK = 1'b1; DC = 1'b0; SDIN = 1'b0;
        repeat (4) @(negedge CLK100MHZ);
        RST = 1'b0;
        repeat (2) @(negedge CLK100MHZ);
        model_reset();
        obs_bytes.delete(); obs_wrs.delete();
        exp_b_data.delete(); exp_b_dc.delete(); exp_w_addr.delete(); exp_w_data.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({byte_valid, byte_data, byte_dc, wr_en, wr_addr, wr_data, disp_on, cmd_err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got bv=%b bd=%02h dc=%b we=%b wa=%0d wd=%02h on=%b err=%b required all 0",
                     byte_valid, byte_data, byte_dc, wr_en, wr_addr, wr_data, disp_on, cmd_err);
        end
    endtask

    task automatic test_disp_on();
        do_reset();
        send_frame(8'hAF, 1'b0);
        flush();
        checks++;
        if (obs_bytes.size() != 1) begin
            fails++; $display("FAIL disp_byte_count: got %0d required 1", obs_bytes.size());
        end
        if (obs_bytes.size() >= 1) begin
            checks++;
            if (obs_bytes[0].data !== 8'hAF || obs_bytes[0].dc !== 1'b0) begin
                fails++; $display("FAIL disp_byte: got %02h/dc%b required af/dc0", obs_bytes[0].data, obs_bytes[0].dc);
            end
        end
        checks++;
        if (disp_on !== 1'b1) begin
            fails++; $display("FAIL disp_on: got %b required 1", disp_on);
        end
        checks++;
        if (obs_wrs.size() != 0) begin
            fails++; $display("FAIL disp_no_write: got %0d writes required 0", obs_wrs.size());
        end
    endtask

    task automatic test_col_window();
        int exp_a[3] = '{126, 127, 254};
        logic [7:0] exp_d[3] = '{8'h11, 8'h22, 8'h33};
        do_reset();
        cs_assert();
        send_byte(8'h21, 1'b0); send_byte(8'h7E, 1'b0); send_byte(8'h7F, 1'b0);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
        cs_release();
        flush();
        checks++;
        if (obs_wrs.size() != 3) begin
            fails++; $display("FAIL colwin_count: got %0d required 3", obs_wrs.size());
        end
        for (int i = 0; i < 3 && i < obs_wrs.size(); i++) begin
            checks++;
            if (int'(obs_wrs[i].addr) != exp_a[i] || obs_wrs[i].data !== exp_d[i]) begin
                fails++;
                $display("FAIL colwin_write[%0d]: got %0d/%02h required %0d/%02h",
                         i, obs_wrs[i].addr, obs_wrs[i].data, exp_a[i], exp_d[i]);
            end
            if (obs_bytes.size() == 6) begin
                checks++;
                if (obs_wrs[i].t != obs_bytes[3 + i].t + 1) begin
                    fails++;
                    $display("FAIL colwin_latency[%0d]: got wr at %0d required %0d",
                             i, obs_wrs[i].t, obs_bytes[3 + i].t + 1);
                end
            end
        end
    endtask

    task automatic test_page_col_cmds();
        do_reset();
        cs_assert();
        send_byte(8'hB3, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h12, 1'b0);
        send_byte(8'hA5, 1'b1);
        cs_release();
        flush();
        checks++;
        if (obs_wrs.size() != 1) begin
            fails++; $display("FAIL pagecol_count: got %0d required 1", obs_wrs.size());
        end else begin
            checks++;
            if (obs_wrs[0].addr !== 9'd421 || obs_wrs[0].data !== 8'hA5) begin
                fails++;
                $display("FAIL pagecol_write: got %0d/%02h required 421/a5", obs_wrs[0].addr, obs_wrs[0].data);
            end
        end
    endtask

    task automatic test_fill_wrap();
        logic [7:0] sent[$];
        logic [7:0] b;
        do_reset();
        cs_assert();
        for (int i = 0; i < NUM_COLS * NUM_PAGES + 1; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            send_byte(b, 1'b1);
        end
        cs_release();
        flush();
        checks++;
        if (obs_wrs.size() != sent.size()) begin
            fails++; $display("FAIL fill_count: got %0d required %0d", obs_wrs.size(), sent.size());
        end
        for (int i = 0; i < sent.size() && i < obs_wrs.size(); i++) begin
            checks++;
            if (int'(obs_wrs[i].addr) != i % (NUM_COLS * NUM_PAGES) || obs_wrs[i].data !== sent[i]) begin
                fails++;
                $display("FAIL fill_write[%0d]: got %0d/%02h required %0d/%02h", i,
                         obs_wrs[i].addr, obs_wrs[i].data, i % (NUM_COLS * NUM_PAGES), sent[i]);
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        cs_assert();
        DC = 1'b1;
        for (int i = 0; i < 5; i++) spi_bit(1'($urandom));
        $display("[%0t] tx partial 5 bits then CS high", $time);
        cs_release();
        flush();
        checks++;
        if (cmd_err !== 1'b1 || obs_bytes.size() != 0) begin
            fails++; $display("FAIL abort_err: got err=%b bytes=%0d required err=1 bytes=0", cmd_err, obs_bytes.size());
        end
        send_frame(8'h3C, 1'b1);
        flush();
        checks++;
        if (obs_bytes.size() != 1 || obs_wrs.size() != 1) begin
            fails++; $display("FAIL abort_counts: got bytes=%0d writes=%0d required 1/1", obs_bytes.size(), obs_wrs.size());
        end else begin
            checks++;
            if (obs_bytes[0].data !== 8'h3C || obs_bytes[0].dc !== 1'b1 ||
                obs_wrs[0].addr !== '0 || obs_wrs[0].data !== 8'h3C) begin
                fails++;
                $display("FAIL abort_byte: got %02h/dc%b at %0d required 3c/dc1 at 0",
                         obs_bytes[0].data, obs_bytes[0].dc, obs_wrs[0].addr);
            end
        end
        checks++;
        if (cmd_err !== 1'b1) begin
            fails++; $display("FAIL abort_sticky: got %b required 1", cmd_err);
        end
    endtask

    task automatic test_skip_arg();
        do_reset();
        cs_assert();
        send_byte(8'hAF, 1'b0); send_byte(8'h81, 1'b0); send_byte(8'hAE, 1'b0);
        cs_release();
        flush();
        checks++;
        if (disp_on !== 1'b1 || obs_bytes.size() != 3) begin
            fails++; $display("FAIL skip_arg: got disp_on=%b bytes=%0d required 1/3", disp_on, obs_bytes.size());
        end
        send_frame(8'hAE, 1'b0);
        flush();
        checks++;
        if (disp_on !== 1'b0) begin
            fails++; $display("FAIL skip_return: got disp_on=%b required 0", disp_on);
        end
    endtask

    task automatic test_reset_mid_byte();
        do_reset();
        send_frame(8'hAF, 1'b0);
        send_frame(8'h5A, 1'b1);
        cs_assert();
        DC = 1'b1;
        for (int i = 0; i < 3; i++) spi_bit(1'b1);
        SCLK = 1'b0; SDIN = 1'b1;
        repeat (2) @(negedge CLK100MHZ);
        $display("[%0t] tx RST during bit 4", $time);
        RST = 1'b1;
        @(negedge CLK100MHZ);
        checks++;
        if ({byte_valid, byte_data, byte_dc, wr_en, wr_addr, wr_data, disp_on, cmd_err} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got bv=%b bd=%02h dc=%b we=%b wa=%0d wd=%02h on=%b err=%b required all 0",
                     byte_valid, byte_data, byte_dc, wr_en, wr_addr, wr_data, disp_on, cmd_err);
        end
        obs_bytes.delete(); obs_wrs.delete();
        RST = 1'b0; CS = 1'b1;
        repeat (6) @(negedge CLK100MHZ);
        SCLK = 1'b1;
        repeat (20) @(negedge CLK100MHZ);
        checks++;
        if (obs_bytes.size() != 0 || obs_wrs.size() != 0 || cmd_err !== 1'b0) begin
            fails++; $display("FAIL midreset_quiet: got bytes=%0d writes=%0d err=%b required 0/0/0",
                              obs_bytes.size(), obs_wrs.size(), cmd_err);
        end
        model_reset();
        send_frame(8'hC3, 1'b1);
        flush();
        checks++;
        if (obs_wrs.size() != 1) begin
            fails++; $display("FAIL midreset_restart: got %0d writes required 1", obs_wrs.size());
        end else begin
            checks++;
            if (obs_wrs[0].addr !== '0 || obs_wrs[0].data !== 8'hC3) begin
                fails++; $display("FAIL midreset_write: got %0d/%02h required 0/c3", obs_wrs[0].addr, obs_wrs[0].data);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] picks[] = '{8'hAE, 8'hAF, 8'h20, 8'h8D, 8'hDA, 8'h26, 8'h2A, 8'hA3, 8'hE3, 8'h40};
        int kind;
        do_reset();
        cs_assert();
        for (int s = 0; s < 140; s++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0, 1, 2, 3: send_byte(8'($urandom), 1'b1);
                4: begin
                    send_byte(8'h21, 1'b0);
                    send_byte(8'($urandom), 1'b0);
                    send_byte(8'($urandom), 1'b0);
                end
                5: begin
                    send_byte(8'h22, 1'b0);
                    send_byte(8'($urandom_range(0, 7)), 1'b0);
                    send_byte(8'($urandom_range(0, 7)), 1'b0);
                end
                6: send_byte(8'($urandom_range(0, 8'h17)), 1'b0);
                7: send_byte(8'hB0 + 8'($urandom_range(0, 7)), 1'b0);
                8: send_byte(picks[$urandom_range(0, 9)], 1'b0);
                default: send_byte(8'($urandom), 1'b0);
            endcase
            if ($urandom_range(0, 7) == 0) begin
                cs_release();
                cs_assert();
            end
        end
        cs_release();
        flush();
        checks++;
        if (obs_bytes.size() != exp_b_data.size() || obs_wrs.size() != exp_w_addr.size()) begin
            fails++; $display("FAIL rand_counts: got bytes=%0d writes=%0d required %0d/%0d",
                              obs_bytes.size(), obs_wrs.size(), exp_b_data.size(), exp_w_addr.size());
        end
        for (int i = 0; i < obs_bytes.size() && i < exp_b_data.size(); i++) begin
            checks++;
            if (obs_bytes[i].data !== exp_b_data[i] || obs_bytes[i].dc !== exp_b_dc[i]) begin
                fails++; $display("FAIL rand_byte[%0d]: got %02h/dc%b required %02h/dc%b", i,
                                  obs_bytes[i].data, obs_bytes[i].dc, exp_b_data[i], exp_b_dc[i]);
            end
        end
        for (int i = 0; i < obs_wrs.size() && i < exp_w_addr.size(); i++) begin
            checks++;
            if (int'(obs_wrs[i].addr) != exp_w_addr[i] || obs_wrs[i].data !== exp_w_data[i]) begin
                fails++; $display("FAIL rand_write[%0d]: got %0d/%02h required %0d/%02h", i,
                                  obs_wrs[i].addr, obs_wrs[i].data, exp_w_addr[i], exp_w_data[i]);
            end
        end
        checks++;
        if (int'(disp_on) != m_disp) begin
            fails++; $display("FAIL rand_disp: got %b required %0d", disp_on, m_disp);
        end
    endtask

    initial begin
        test_reset();
        test_disp_on();
        test_col_window();
        test_page_col_cmds();
        test_fill_wrap();
        test_abort();
        test_skip_arg();
        test_reset_mid_byte();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
